// File: rtl/bcd_scan_display.sv
// Scans a captured packed-BCD word across a shared 7-segment bus with one-hot digit enables and a frame strobe.
// Fully registered outputs. Optional leading-zero blanking is enabled with the BCD_SCAN_LZB_EN macro.
module bcd_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic                    slot_end;
    logic                    last_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

`ifdef BCD_SCAN_LZB_EN
    // blank_vec[i] is set when digits i..top are all zero; digit 0 always shows.
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  lead_zero;

    always_comb begin
        blank_vec = '0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero    = lead_zero & (shadow_q[4*i +: 4] == 4'd0);
            blank_vec[i] = lead_zero;
        end
        cur_blank = blank_vec[idx_q];
    end
`else
    assign cur_blank = 1'b0;
`endif

    assign cur_digit  = shadow_q[4*idx_q +: 4];
    assign slot_end   = (div_q == DIV_LAST);
    assign last_digit = (idx_q == IDX_LAST);

    always_comb begin
        shadow_d = load ? digits_in : shadow_q;
        div_d    = div_q;
        idx_d    = idx_q;
        seg_d    = 7'h00;
        an_d     = '0;
        fd_d     = 1'b0;
        if (en) begin
            seg_d = cur_blank ? 7'h00 : decode(cur_digit);
            an_d  = NUM_DIGITS'(1) << idx_q;
            fd_d  = last_digit && slot_end;
            if (slot_end) begin
                div_d = '0;
                idx_d = last_digit ? '0 : idx_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            div_q    <= '0;
            idx_q    <= '0;
            seg_q    <= 7'h00;
            an_q     <= '0;
            fd_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: constant vector table, hand sequences and a model-fed scoreboard.
module tb_bcd_scan_display;

    localparam int N = 4;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    bcd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    typedef struct {
        logic        rst, en, load;
        logic [15:0] din;
        int          reps;
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        fd_last;
    } vec_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] m_shadow = 16'h0;
    int          m_pos = 0;
    logic [6:0]  dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    function automatic logic model_blank(input int dig);
`ifdef BCD_SCAN_LZB_EN
        if (dig == 0) return 1'b0;
        for (int j = dig; j < N; j++)
            if (m_shadow[4*j +: 4] != 4'd0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_out(input string tag);
        exp_t x;
        x = sbq.pop_front();
        checks++;
        if (seg !== x.seg) begin
            errors++;
            $display("FAIL %s seg: got %02h expected %02h (t=%0t)", tag, seg, x.seg, $time);
        end
        checks++;
        if (an !== x.an) begin
            errors++;
            $display("FAIL %s an: got %04b expected %04b (t=%0t)", tag, an, x.an, $time);
        end
        checks++;
        if (frame_done !== x.fd) begin
            errors++;
            $display("FAIL %s frame_done: got %0b expected %0b (t=%0t)", tag, frame_done, x.fd, $time);
        end
    endtask

    // One clock: drive inputs, push the expected post-edge outputs, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic l, input logic [15:0] d,
                        input logic use_tab, input exp_t tab_exp, input string tag);
        exp_t m;
        int   dig;
        @(negedge clk);
        rst = r; en = e; load = l; digits_in = d;
        m = '{7'h00, 4'h0, 1'b0};
        if (r) begin
            m_shadow = 16'h0;
            m_pos    = 0;
        end else begin
            if (e) begin
                dig   = m_pos / S;
                m.seg = model_blank(dig) ? 7'h00 : dec_tab[m_shadow[4*dig +: 4]];
                m.an  = 4'(1 << dig);
                m.fd  = (m_pos == N*S - 1);
                m_pos = (m_pos + 1) % (N*S);
            end
            if (l) m_shadow = d;
        end
        sbq.push_back(use_tab ? tab_exp : m);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic mstep(input logic r, input logic e, input logic l, input logic [15:0] d, input string tag);
        step(r, e, l, d, 1'b0, '{7'h00, 4'h0, 1'b0}, tag);
    endtask

    task automatic xstep(input logic e, input logic l, input logic [15:0] d,
                         input logic [6:0] s, input logic [3:0] a, input logic f, input string tag);
        step(1'b0, e, l, d, 1'b1, '{s, a, f}, tag);
    endtask

    vec_t vecs [11];
    logic [6:0] lz_exp [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset blocks load; invalid nibbles render as dash.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 2, 7'h00, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 7'h3F, 4'b0001, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 7'h3F, 4'b0001, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1, 7'h00, 4'b0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'hF9A0, 1, 7'h00, 4'b0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 7'h3F, 4'b0001, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 7'h40, 4'b0010, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 7'h6F, 4'b0100, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 7'h40, 4'b1000, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 7'h3F, 4'b0001, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2, 7'h00, 4'b0000, 1'b0};

        for (int v = 0; v < 11; v++)
            for (int r = 0; r < vecs[v].reps; r++)
                step(vecs[v].rst, vecs[v].en, vecs[v].load, vecs[v].din, 1'b1,
                     '{vecs[v].seg, vecs[v].an, vecs[v].fd_last && (r == vecs[v].reps - 1)},
                     $sformatf("vec%0d", v));

        // Scan order over two frames of 4321.
        mstep(1'b1, 1'b0, 1'b0, 16'h0, "scan_rst");
        mstep(1'b0, 1'b0, 1'b1, 16'h4321, "scan_load");
        for (int i = 0; i < 2*N*S; i++) mstep(1'b0, 1'b1, 1'b0, 16'h0, "scan_order");

        // Enable dropped after two cycles of digit 2.
        mstep(1'b1, 1'b0, 1'b0, 16'h0, "hold_rst");
        mstep(1'b0, 1'b0, 1'b1, 16'h4321, "hold_load");
        for (int i = 0; i < 10; i++) mstep(1'b0, 1'b1, 1'b0, 16'h0, "hold_pre");
        for (int i = 0; i < 5; i++) xstep(1'b0, 1'b0, 16'h0, 7'h00, 4'b0000, 1'b0, "hold_blank");
        for (int i = 0; i < 2; i++) xstep(1'b1, 1'b0, 16'h0, 7'h4F, 4'b0100, 1'b0, "hold_resume");
        for (int i = 0; i < 3; i++) xstep(1'b1, 1'b0, 16'h0, 7'h66, 4'b1000, 1'b0, "hold_dig3");
        xstep(1'b1, 1'b0, 16'h0, 7'h66, 4'b1000, 1'b1, "hold_frame");
        xstep(1'b1, 1'b0, 16'h0, 7'h06, 4'b0001, 1'b0, "hold_wrap");

        // Load while digit 1 is being shown.
        mstep(1'b1, 1'b0, 1'b0, 16'h0, "ld_rst");
        mstep(1'b0, 1'b0, 1'b1, 16'h4321, "ld_load");
        for (int i = 0; i < 5; i++) mstep(1'b0, 1'b1, 1'b0, 16'h0, "ld_pre");
        xstep(1'b1, 1'b1, 16'h8888, 7'h5B, 4'b0010, 1'b0, "ld_old");
        xstep(1'b1, 1'b0, 16'h0, 7'h7F, 4'b0010, 1'b0, "ld_new");
        for (int i = 0; i < 2*N*S; i++) mstep(1'b0, 1'b1, 1'b0, 16'h0, "ld_post");

        // Leading zeros on 0050.
`ifdef BCD_SCAN_LZB_EN
        lz_exp = '{7'h3F, 7'h6D, 7'h00, 7'h00};
`else
        lz_exp = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
`endif
        mstep(1'b1, 1'b0, 1'b0, 16'h0, "lz_rst");
        mstep(1'b0, 1'b0, 1'b1, 16'h0050, "lz_load");
        for (int d = 0; d < N; d++)
            for (int r = 0; r < S; r++)
                xstep(1'b1, 1'b0, 16'h0, lz_exp[d], 4'(1 << d), (d == N-1) && (r == S-1),
                      $sformatf("lz_dig%0d", d));

        // Random mix of enable, load and reset against the model.
        for (int i = 0; i < 400; i++)
            mstep(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 9) == 0), 16'($urandom), "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Display-side consumer for the decimal (BCD) counters.
- Captures a multi-digit packed BCD word and time-multiplexes it onto a common 7-segment bus.
- Produces one-hot digit enables, decoded segments, and a per-frame strobe.
- Sits between the decimal counter chain and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned (2..8).
- SCAN_DIV, 4, clock cycles each digit stays active (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable; 0 blanks outputs and freezes the scan position.
- load  input  1  capture digits_in into the shadow register.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit 0 in bits [3:0].
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- an  output  NUM_DIGITS  one-hot digit enable, active-high; bit i selects digit i.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): shadow=0, div_cnt=0, idx=0, seg=0, an=0, frame_done=0. rst has priority over load and en.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Load:
  - When load=1 at an edge, shadow <= digits_in. This happens regardless of en.
  - The new shadow affects seg from the following edge onward.
  - The edge that samples load still displays the old shadow.
- Scan, en=1, at each edge:
  - seg <= decode(shadow digit idx); an <= one-hot(idx).
  - If div_cnt==SCAN_DIV-1: div_cnt <= 0 and idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - Otherwise div_cnt <= div_cnt+1.
  - frame_done <= (idx==NUM_DIGITS-1 && div_cnt==SCAN_DIV-1). Otherwise frame_done <= 0.
- Blanking, en=0: seg <= 0, an <= 0, frame_done <= 0. div_cnt and idx hold. The scan resumes from the held position when en returns to 1.
- Timing:
  - Each digit is visible for exactly SCAN_DIV consecutive cycles.
  - A full frame is NUM_DIGITS*SCAN_DIV cycles.
  - Latency: an/seg reflect idx one cycle after it is sampled.
- Decode, gfedcba hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any nibble 10..15 displays a dash (40).
- Width rules:
  - div_cnt width = clog2(SCAN_DIV), minimum 1 bit.
  - idx width = clog2(NUM_DIGITS).
  - No value outside 0..SCAN_DIV-1 or 0..NUM_DIGITS-1 is ever reachable.
- Simultaneous events: load with en=1 updates shadow and advances the scan on the same edge. Reset mid-frame restarts at digit 0 with the shadow cleared.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit i (i>0) shows seg=00 while its an bit still asserts.
  - This applies when shadow digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked. Invalid nibbles count as non-zero.
- Undefined: every digit is decoded normally; zeros display as 3F.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles with en=1, load=1, digits_in=16'h1234. Required: seg=00, an=0000, frame_done=0, and the shadow is not loaded. After release with en=1 and no load: first edge gives an=0001, seg=3F.
- Scan order: load 16'h4321, then en=1. Required:
  - an steps 0001→0010→0100→1000, 4 cycles each.
  - seg follows 06, 5B, 4F, 66.
  - frame_done pulses high for exactly 1 cycle, on the cycle after an=1000's 4th cycle edge.
  - The pattern repeats with period 16.
- Invalid digit: load 16'hF9A0. Required: digit0=3F, digit1=40, digit2=6F, digit3=40.
- Enable hold: drop en for 5 cycles in the middle of digit 2's slot. Required:
  - an=0000 and seg=00 while en is low.
  - On re-enable, digit 2 completes its remaining slot cycles with no skip and no frame_done glitch.
- Load during scan: load 16'h8888 while digit 1 is active. Required: the edge that samples load shows the old value; the next edge shows 7F.
- BCD_SCAN_LZB_EN defined: load 16'h0050. Required:
  - Digit3 and digit2 show seg=00 with an still asserted.
  - Digit1=6D, digit0=3F.
  - With the macro undefined, digit3 and digit2 show 3F.
